// File: rtl/k_calculator_if.sv
// Handshake bundle between the K calculator and its user: adjust/freq_sel in, K result and status out.
interface k_calculator_if #(
    parameter int unsigned SEL_W = 8,
    parameter int unsigned K_W   = 16
) ();
    logic             adjust;
    logic [SEL_W-1:0] freq_sel;
    logic [K_W-1:0]   k_out;
    logic             kcalc;
    logic             busy;

    modport master (output adjust, output freq_sel, input k_out, input kcalc, input busy);
    modport slave  (input adjust, input freq_sel, output k_out, output kcalc, output busy);
endinterface

// File: rtl/k_calculator.sv
// Computes K = floor(NUM / freq_sel) with a one-bit-per-clock restoring divider after adjust release.
// Optional macro ROUND_NEAREST_EN adds a ROUND state producing round-to-nearest K (saturating).
module k_calculator #(
    parameter int unsigned SEL_W = 8,
    parameter int unsigned K_W   = 16,
    parameter int unsigned NUM   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    k_calculator_if.slave    bus
);

    localparam int unsigned REM_W = SEL_W + 1;
    localparam int unsigned CNT_W = (K_W > 1) ? $clog2(K_W) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ARMED  = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
`ifdef ROUND_NEAREST_EN
    localparam int unsigned RND_W = SEL_W + 2;
    localparam logic [2:0] ROUND  = 3'd4;
`endif

    logic [2:0]       state_q,   state_nxt;
    logic [SEL_W-1:0] divisor_q, divisor_nxt;
    logic [REM_W-1:0] rem_q,     rem_nxt;
    logic [K_W-1:0]   work_q,    work_nxt;
    logic [CNT_W-1:0] cnt_q,     cnt_nxt;
    logic [K_W-1:0]   k_q,       k_nxt;
    logic             kcalc_q,   kcalc_nxt;
    logic             busy_q,    busy_nxt;

    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] rem_step;
    logic             rem_ge;
    logic [K_W-1:0]   work_step;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            divisor_q <= '0;
            rem_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            kcalc_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            divisor_q <= divisor_nxt;
            rem_q     <= rem_nxt;
            work_q    <= work_nxt;
            cnt_q     <= cnt_nxt;
            k_q       <= k_nxt;
            kcalc_q   <= kcalc_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Next-state, divider step and output decode
    always_comb begin
        state_nxt   = state_q;
        divisor_nxt = divisor_q;
        rem_nxt     = rem_q;
        work_nxt    = work_q;
        cnt_nxt     = cnt_q;
        k_nxt       = k_q;

        // rem < divisor always holds, so its MSB is zero before the shift
        rem_sh    = {rem_q[SEL_W-1:0], work_q[K_W-1]};
        rem_ge    = (rem_sh >= {1'b0, divisor_q});
        rem_step  = rem_ge ? (rem_sh - {1'b0, divisor_q}) : rem_sh;
        work_step = {work_q[K_W-2:0], rem_ge};

        case (state_q)
            IDLE: begin
                if (bus.adjust) state_nxt = ARMED;
            end
            ARMED: begin
                if (!bus.adjust) begin
                    divisor_nxt = bus.freq_sel;
                    rem_nxt     = '0;
                    work_nxt    = K_W'(NUM);
                    cnt_nxt     = CNT_W'(K_W - 1);
                    if (bus.freq_sel == '0) begin
                        k_nxt     = '1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                // A new adjust press wins over completion, even on the last bit
                if (bus.adjust) begin
                    state_nxt = ARMED;
                end else begin
                    rem_nxt  = rem_step;
                    work_nxt = work_step;
                    cnt_nxt  = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
`ifdef ROUND_NEAREST_EN
                        state_nxt = ROUND;
`else
                        k_nxt     = work_step;
                        state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef ROUND_NEAREST_EN
            ROUND: begin
                if (bus.adjust) begin
                    state_nxt = ARMED;
                end else begin
                    if (({rem_q, 1'b0} >= RND_W'(divisor_q)) && (work_q != '1))
                        k_nxt = work_q + K_W'(1);
                    else
                        k_nxt = work_q;
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.adjust) state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase

        kcalc_nxt = (state_nxt == DONE);
`ifdef ROUND_NEAREST_EN
        busy_nxt  = (state_nxt == DIVIDE) || (state_nxt == ROUND);
`else
        busy_nxt  = (state_nxt == DIVIDE);
`endif
    end

    assign bus.k_out = k_q;
    assign bus.kcalc = kcalc_q;
    assign bus.busy  = busy_q;

endmodule
